ss_disp_mux: RTL



---
 rtl/ss_disp_pkg.sv | 23 ++
 rtl/ss_hex_dec.sv | 41 ++++
 rtl/ss_disp_mux.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ss_disp_pkg.sv
// Shared constants for the seven-segment display mux.
// Glyphs are active low, bit order abcdefg (a = bit 6).
package ss_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ss_hex_dec.sv
// Combinational 4-bit value to active-low segment decoder.
// Hex glyphs for 10..15 only when HEX_EN is set, else blank.
module ss_hex_dec
  import ss_disp_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] val_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  localparam bit HEX = (HEX_EN != 0);

  logic [6:0] glyph;

  // Value to glyph lookup, then forced blank override.
  always_comb begin
    glyph = SEG_BLANK;
    unique case (val_i)
      4'd0:  glyph = SEG_0;
      4'd1:  glyph = SEG_1;
      4'd2:  glyph = SEG_2;
      4'd3:  glyph = SEG_3;
      4'd4:  glyph = SEG_4;
      4'd5:  glyph = SEG_5;
      4'd6:  glyph = SEG_6;
      4'd7:  glyph = SEG_7;
      4'd8:  glyph = SEG_8;
      4'd9:  glyph = SEG_9;
      4'd10: glyph = HEX ? SEG_A : SEG_BLANK;
      4'd11: glyph = HEX ? SEG_B : SEG_BLANK;
      4'd12: glyph = HEX ? SEG_C : SEG_BLANK;
      4'd13: glyph = HEX ? SEG_D : SEG_BLANK;
      4'd14: glyph = HEX ? SEG_E : SEG_BLANK;
      4'd15: glyph = HEX ? SEG_F : SEG_BLANK;
    endcase
    seg_o = blank_i ? SEG_BLANK : glyph;
  end

endmodule

// File: rtl/ss_disp_mux.sv
// Time-multiplexed common-anode seven-segment driver.
// Prescaler, digit index, scan snapshot, LZ blanking, output regs.
module ss_disp_mux
  import ss_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int DEAD_CYC   = 2,
  parameter int HEX_EN     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  run_q, run_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [NUM_DIGITS-1:0] dpi_q, dpi_d;
  logic [NUM_DIGITS-1:0] blk_q, blk_d;
  logic                  lz_q, lz_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  take;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;
  logic [3:0]            sel_val;
  logic                  sel_blank;
  logic                  sel_dp;
  logic [6:0]            dec_seg;
  logic                  active;

  // Scan sequencing and snapshot capture.
  // A new snapshot is taken at scan start or on enable rising.
  always_comb begin
    run_d = en;
    cnt_d = cnt_q;
    idx_d = idx_q;
    take  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (!run_q) begin
      cnt_d = '0;
      idx_d = '0;
      take  = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
        take  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    dig_d = take ? digits   : dig_q;
    dpi_d = take ? dp_in    : dpi_q;
    blk_d = take ? blank_in : blk_q;
    lz_d  = take ? lz_blank : lz_q;
  end

  // Leading-zero mask: blank a zero digit when all higher ones are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (dig_d[4*i +: 4] == 4'd0);
      lz_mask[i] = lz_d && (i != 0) && zero_above;
    end
  end

  // Pick the digit addressed by the next-state index.
  always_comb begin
    sel_val   = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        sel_val   = dig_d[4*i +: 4];
        sel_blank = blk_d[i] | lz_mask[i];
        sel_dp    = dpi_d[i];
      end
    end
  end

  ss_hex_dec #(
    .HEX_EN (HEX_EN)
  ) u_dec (
    .val_i   (sel_val),
    .blank_i (sel_blank),
    .seg_o   (dec_seg)
  );

  // Output next-state; dead time at slot start keeps all lines off.
  always_comb begin
    active = en && (cnt_d >= DEAD);
    an_d   = '1;
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    if (active) begin
      an_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
      seg_d = dec_seg;
      dp_d  = ~sel_dp;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
      dig_q <= '0;
      dpi_q <= '0;
      blk_q <= '0;
      lz_q  <= 1'b0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      run_q <= run_d;
      dig_q <= dig_d;
      dpi_q <= dpi_d;
      blk_q <= blk_d;
      lz_q  <= lz_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
